// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        TRAP = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } fetch_err_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_queue.sv
// Small circular fetch queue of {pc, instr} entries with flush.
// An empty queue presents pc 0 and the NOP as its head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int unsigned IDXW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [IDXW:0] PTR_ONE = {{IDXW{1'b0}}, 1'b1};

    // The extra MSB tells a wrapped-around full queue from an empty one.
    logic [IDXW:0] wr_ptr_q;
    logic [IDXW:0] rd_ptr_q;
    fetch_entry_t  mem_q [QDEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IDXW] != rd_ptr_q[IDXW]) &&
                     (wr_ptr_q[IDXW-1:0] == rd_ptr_q[IDXW-1:0]);

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDXW-1:0]] <= wdata_i;
    end

    always_comb begin
        head_o.pc    = '0;
        head_o.instr = NOP_INSTR;
        if (!empty_o) head_o = mem_q[rd_ptr_q[IDXW-1:0]];
    end

endmodule

// File: rtl/fetch_unit.sv
// RV64 fetch stage: owns the PC, drives instr_mem, queues fetched words for
// decode, and handles execute redirects and traps on illegal fetch targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        mem_read,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_instr,
    input  logic        mem_instr_valid,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    localparam logic [63:0] IMEM_BYTES = 64'(IMEM_DEPTH) * 64'd4;

    fetch_state_t state_q;
    fetch_err_t   err_q;
    logic         fetch_err_q;
    logic [63:0]  pc_q;

    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_wdata;

    logic         redirect_act;
    logic         pop_req;
    logic         push;
    logic [63:0]  pc_next;

    assign redirect_act = redirect_valid && (state_q != BOOT);
    assign if_valid     = !q_empty;
    assign pop_req      = if_valid && id_ready;

    // A full queue may still fetch when the head leaves in the same cycle.
    assign mem_read = (state_q == RUN) && (!q_full || pop_req);
    assign mem_addr = pc_q;
    assign push     = mem_read && mem_instr_valid && !redirect_act;
    assign pc_next  = pc_q + 64'd4;

    assign q_wdata.pc    = pc_q;
    assign q_wdata.instr = mem_instr;

    assign if_pc     = q_head.pc;
    assign if_instr  = q_head.instr;
    assign fetch_err = fetch_err_q;
    assign err_code  = err_q;

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_act),
        .push_i  (push),
        .pop_i   (pop_req),
        .wdata_i (q_wdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            err_q       <= ERR_NONE;
            fetch_err_q <= 1'b0;
        end else if (redirect_act) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_q     <= TRAP;
                err_q       <= ERR_MISALIGN;
                fetch_err_q <= 1'b1;
            end else if (redirect_pc >= IMEM_BYTES) begin
                state_q     <= TRAP;
                err_q       <= ERR_RANGE;
                fetch_err_q <= 1'b1;
            end else begin
                state_q     <= RUN;
                pc_q        <= redirect_pc;
                err_q       <= ERR_NONE;
                fetch_err_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // The last legal word is still queued; pc parks on it.
                    if (push) begin
                        if (pc_next >= IMEM_BYTES) begin
                            state_q     <= TRAP;
                            err_q       <= ERR_RANGE;
                            fetch_err_q <= 1'b1;
                        end else begin
                            pc_q <= pc_next;
                        end
                    end
                end
                TRAP: state_q <= TRAP;
                default: begin
                    state_q     <= TRAP;
                    err_q       <= ERR_RANGE;
                    fetch_err_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instr_mem model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        mem_read;
    logic [63:0] mem_addr;
    logic [31:0] mem_instr;
    logic        mem_instr_valid;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_err;
    logic [1:0]  err_code;

    logic        mem_ok;
    logic [31:0] imem [1024];

    int unsigned n_checks;
    int unsigned n_pass;

    fetch_unit #(
        .RESET_PC   (64'h0),
        .IMEM_DEPTH (1024),
        .QDEPTH     (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .mem_read        (mem_read),
        .mem_addr        (mem_addr),
        .mem_instr       (mem_instr),
        .mem_instr_valid (mem_instr_valid),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fetch_err       (fetch_err),
        .err_code        (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_instr = 32'h0;
        if (mem_addr < 64'd4096) mem_instr = imem[mem_addr[11:2]];
    end
    assign mem_instr_valid = mem_read && mem_ok;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_mem_read"},  64'(mem_read),  64'd0);
        check({pfx, "_mem_addr"},  mem_addr,       64'h0);
        check({pfx, "_if_valid"},  64'(if_valid),  64'd0);
        check({pfx, "_if_pc"},     if_pc,          64'h0);
        check({pfx, "_if_instr"},  64'(if_instr),  64'h13);
        check({pfx, "_fetch_err"}, 64'(fetch_err), 64'd0);
        check({pfx, "_err_code"},  64'(err_code),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int unsigned i = 0; i < 1024; i++) imem[i] = 32'h10000000 | i;
        imem[0] = 32'h00500093;
        imem[1] = 32'h00500113;

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        mem_ok         = 1'b1;
        #2;
        check_reset_vals("rst");

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("boot_mem_read", 64'(mem_read), 64'd0);
        step();
        check("run_mem_read", 64'(mem_read), 64'd1);
        check("run_mem_addr", mem_addr, 64'h0);
        check("run_if_valid", 64'(if_valid), 64'd0);
        step();
        check("e0_pc", if_pc, 64'h0);
        check("e0_instr", 64'(if_instr), 64'h00500093);
        check("e0_mem_addr", mem_addr, 64'h4);
        step();
        check("e1_pc", if_pc, 64'h4);
        check("e1_instr", 64'(if_instr), 64'h00500113);
        mem_ok = 1'b0;
        step();
        check("nv_if_valid", 64'(if_valid), 64'd0);
        check("nv_pc_hold", mem_addr, 64'h8);
        mem_ok = 1'b1;
        step();
        check("e2_pc", if_pc, 64'h8);
        check("e2_instr", 64'(if_instr), 64'h10000002);

        id_ready = 1'b0;
        do_reset();
        step();
        step();
        check("full_mem_read", 64'(mem_read), 64'd0);
        step();
        step();
        check("stall_pc_hold", mem_addr, 64'h8);
        check("stall_head", if_pc, 64'h0);
        step();
        id_ready = 1'b1;
        #1;
        check("fullpop_mem_read", 64'(mem_read), 64'd1);
        step();
        check("drain_pc4", if_pc, 64'h4);
        step();
        check("drain_pc8", if_pc, 64'h8);
        check("drain_instr8", 64'(if_instr), 64'h10000002);

        redirect(64'h40);
        check("rd_flush", 64'(if_valid), 64'd0);
        check("rd_mem_addr", mem_addr, 64'h40);
        step();
        check("rd_pc", if_pc, 64'h40);
        check("rd_instr", 64'(if_instr), 64'h10000010);

        redirect(64'h42);
        check("mis_fetch_err", 64'(fetch_err), 64'd1);
        check("mis_err_code", 64'(err_code), 64'd1);
        check("mis_mem_read", 64'(mem_read), 64'd0);
        step();
        check("mis_mem_read2", 64'(mem_read), 64'd0);
        check("mis_if_valid", 64'(if_valid), 64'd0);
        redirect(64'h10);
        check("rec_fetch_err", 64'(fetch_err), 64'd0);
        check("rec_err_code", 64'(err_code), 64'd0);
        check("rec_mem_read", 64'(mem_read), 64'd1);
        step();
        check("rec_pc", if_pc, 64'h10);
        check("rec_instr", 64'(if_instr), 64'h10000004);

        redirect(64'hFFC);
        check("ovr_mem_addr", mem_addr, 64'hFFC);
        check("ovr_no_err", 64'(fetch_err), 64'd0);
        step();
        check("ovr_last_pc", if_pc, 64'hFFC);
        check("ovr_last_instr", 64'(if_instr), 64'h100003FF);
        check("ovr_fetch_err", 64'(fetch_err), 64'd1);
        check("ovr_err_code", 64'(err_code), 64'd2);
        check("ovr_mem_read", 64'(mem_read), 64'd0);
        check("ovr_pc_hold", mem_addr, 64'hFFC);
        step();
        check("trap_drained", 64'(if_valid), 64'd0);
        redirect(64'h3);
        check("trap_bad_code", 64'(err_code), 64'd1);
        check("trap_bad_err", 64'(fetch_err), 64'd1);
        redirect(64'h10);
        step();
        redirect(64'h1000);
        check("rng_fetch_err", 64'(fetch_err), 64'd1);
        check("rng_err_code", 64'(err_code), 64'd2);
        check("rng_mem_read", 64'(mem_read), 64'd0);
        check("rng_flush", 64'(if_valid), 64'd0);

        id_ready = 1'b0;
        redirect(64'h20);
        step();
        step();
        check("pre_rst_valid", 64'(if_valid), 64'd1);
        check("pre_rst_addr", mem_addr, 64'h28);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("arst");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        id_ready       = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        redirect_valid = 1'b0;
        #1;
        check("boot_ign_addr", mem_addr, 64'h0);
        step();
        check("post_rst_pc", if_pc, 64'h0);
        check("post_rst_instr", 64'(if_instr), 64'h00500093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- RV64 instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the PC and drives MemRead/mem_addr into instr_mem, which returns instr and instr_valid in the same cycle.
- Captures {pc, instr} pairs into a small fetch queue and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute and traps on bad fetch targets.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- IMEM_DEPTH, 1024, instr_mem depth in 32-bit words; legal PCs are 0 .. IMEM_DEPTH*4-4.
- QDEPTH, 2, fetch-queue entries; must be a power of 2 and >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  redirect request from execute (taken branch/jal/jalr).
- redirect_pc  in  64  redirect target.
- id_ready  in  1  decode accepts the head entry this cycle.
- mem_read  out  1  read enable to instr_mem (MemRead).
- mem_addr  out  64  fetch address to instr_mem, equal to pc.
- mem_instr  in  32  instruction from instr_mem.
- mem_instr_valid  in  1  mem_instr is valid this cycle.
- if_valid  out  1  queue head is valid.
- if_pc  out  64  PC of head entry.
- if_instr  out  32  instruction of head entry.
- fetch_err  out  1  unit is in TRAP.
- err_code  out  2  01 = misaligned target, 10 = out-of-range target, 00 = none.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=BOOT, queue empty.
  - mem_read=0, if_valid=0, if_pc=0, if_instr=32'h00000013, fetch_err=0, err_code=00.
- States:
  - BOOT: one idle cycle after reset deasserts, then RUN.
  - RUN: fetching.
  - TRAP: fetch stopped.
- RUN, fetch:
  - mem_read=1 when the queue is not full, or when it is full and a pop occurs this cycle.
  - mem_addr=pc (combinational from pc register).
- RUN, push: when mem_read && mem_instr_valid, push {pc, mem_instr} at the clock edge and set pc <= pc+4. Arithmetic is mod 2^64.
- RUN, no push: mem_read=1 with mem_instr_valid=0 means no push and pc holds.
- Pop: if_valid && id_ready removes the head at the edge.
- Same-cycle push and pop when full: both occur; occupancy is unchanged.
- Latency: the instruction at pc appears on if_* one cycle after it is fetched, when the queue was empty at fetch time.
- Head outputs: if_pc/if_instr are registered queue-head data. When empty they hold the NOP 32'h00000013 and pc 0.
- Redirect (redirect_valid=1, any state except BOOT):
  - Highest priority: flush the queue, with no push and any pop ignored.
  - Check target. If redirect_pc[1:0]!=0: go to TRAP, err_code=01.
  - Else if redirect_pc >= IMEM_DEPTH*4: go to TRAP, err_code=10.
  - Else pc <= redirect_pc, state <= RUN, err_code <= 00.
  - During the redirect cycle, mem_read is still driven for the old pc, but the result is discarded.
- Sequential overrun: if pc+4 would reach IMEM_DEPTH*4 on a push, push the current entry, then go to TRAP with err_code=10. pc holds at the last legal address.
- TRAP:
  - mem_read=0 and fetch_err=1.
  - The queue keeps draining to decode.
  - Only a legal redirect leaves TRAP; an illegal one stays in TRAP and updates err_code.
- BOOT: redirect is ignored.
- Reset mid-operation: immediate return to the reset values, with all queue contents discarded.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {BOOT, RUN, TRAP}.
  - fetch_err_t 2-bit codes ERR_NONE/ERR_MISALIGN/ERR_RANGE.
  - fetch_entry_t struct {logic [63:0] pc; logic [31:0] instr}.
  - NOP_INSTR = 32'h00000013.
- Sub-module fetch_queue (parameter QDEPTH) provides:
  - push/pop, flush, full/empty and head data over fetch_entry_t.
  - Pointers one bit wider than the index, so full/empty is decided by pointer compare.
- The top level holds the FSM, PC, the range/alignment checks and the instr_mem handshake.

Test Plan:
- Reset, then id_ready=1, memory preloaded with 0x00500093 at word 0 and 0x00500113 at word 1 -> mem_read=0 during BOOT. Next cycle mem_addr=0; one cycle later if_pc=0/if_instr=0x00500093, then if_pc=4/if_instr=0x00500113, with one entry per cycle.
- id_ready=0 for 5 cycles from the start of fetch -> queue fills with pc 0 and 4; mem_read drops to 0 and pc holds at 8. Raising id_ready restores one entry per cycle with no loss or duplication (PCs 0,4,8 in order).
- redirect_valid=1, redirect_pc=0x40 while the queue holds 2 entries -> if_valid=0 the next cycle. The first entry after that is if_pc=0x40; no entry older than the redirect appears.
- Redirect to 0x42 -> fetch_err=1, err_code=01, mem_read=0 from the next cycle on. A following redirect to 0x10 returns to RUN with err_code=00 and if_pc=0x10.
- Redirect to 0xFFC with IMEM_DEPTH=1024 -> entry 0xFFC is delivered, then TRAP with err_code=10. A redirect to 0x1000 traps directly with err_code=10.
- Assert reset asynchronously mid-stream with a full queue -> all outputs take their reset values before the next clock edge. After release, the first if_pc is RESET_PC.
